// File: rtl/free_list.sv
// Physical-register free list: circular tag buffer with allocate, retire-free and squash-to-retire-head recovery.
// Zero-cycle allocation (tags offered combinationally, consumed in request cycle); no backpressure, requests beyond avail_num_o are ignored.
module free_list #(
  parameter int  C_DP_NUM       = 3,
  parameter int  C_RT_NUM       = 3,
  parameter int  C_ARCH_REG_NUM = 32,
  parameter int  C_PHY_REG_NUM  = 64,
  localparam int C_FL_ENTRY_NUM = C_PHY_REG_NUM - C_ARCH_REG_NUM,
  localparam int TAG_IDX_WIDTH  = $clog2(C_PHY_REG_NUM),
  localparam int IDX_W          = $clog2(C_FL_ENTRY_NUM),
  localparam int PTR_W          = IDX_W + 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [C_DP_NUM-1:0]                   dp_fl_i,
  output logic [C_DP_NUM*(TAG_IDX_WIDTH+1)-1:0] fl_dp_o,
  input  logic [C_RT_NUM*(TAG_IDX_WIDTH+1)-1:0] rob_fl_i,
  input  logic                                  exception_i,
  output logic [PTR_W-1:0]                      avail_num_o
);

  localparam int SLOT_W = TAG_IDX_WIDTH + 1;
  localparam logic [PTR_W-1:0] ONE = PTR_W'(1);

  logic [TAG_IDX_WIDTH-1:0] entry_q [C_FL_ENTRY_NUM];
  logic [PTR_W-1:0]         head_q;
  logic [PTR_W-1:0]         tail_q;
  logic [PTR_W-1:0]         rt_head_q;

  logic [PTR_W-1:0]         count;
  logic [PTR_W-1:0]         space;
  logic [PTR_W-1:0]         alloc_num;
  logic [PTR_W-1:0]         free_num;
  logic [PTR_W-1:0]         rt_num;
  logic [PTR_W-1:0]         wr_ptr [C_RT_NUM];
  logic [C_RT_NUM-1:0]      wr_en;

  // Pointers carry a wrap bit, so plain subtraction yields 0..C_FL_ENTRY_NUM.
  assign count       = tail_q - head_q;
  assign space       = PTR_W'(C_FL_ENTRY_NUM) - count;
  assign avail_num_o = count;

  always_comb begin : offer
    logic [PTR_W-1:0] rd_ptr;
    fl_dp_o   = '0;
    alloc_num = '0;
    rd_ptr    = '0;
    for (int n = 0; n < C_DP_NUM; n++) begin
      rd_ptr = head_q + PTR_W'(n);
      fl_dp_o[n*SLOT_W +: SLOT_W] = {count > PTR_W'(n), entry_q[rd_ptr[IDX_W-1:0]]};
      if (dp_fl_i[n] && (count > PTR_W'(n))) begin
        alloc_num = alloc_num + ONE;
      end
    end
  end

  // Frees are packed at the tail in channel order; any beyond free space are dropped.
  always_comb begin : retire
    free_num = '0;
    rt_num   = '0;
    wr_en    = '0;
    for (int k = 0; k < C_RT_NUM; k++) begin
      wr_ptr[k] = tail_q + free_num;
      if (rob_fl_i[k*SLOT_W + TAG_IDX_WIDTH]) begin
        rt_num = rt_num + ONE;
        if (free_num < space) begin
          wr_en[k] = 1'b1;
          free_num = free_num + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < C_FL_ENTRY_NUM; i++) begin
        entry_q[i] <= TAG_IDX_WIDTH'(C_ARCH_REG_NUM + i);
      end
      head_q    <= '0;
      rt_head_q <= '0;
      tail_q    <= PTR_W'(C_FL_ENTRY_NUM);
    end else begin
      for (int k = 0; k < C_RT_NUM; k++) begin
        if (wr_en[k]) begin
          entry_q[wr_ptr[k][IDX_W-1:0]] <= rob_fl_i[k*SLOT_W +: TAG_IDX_WIDTH];
        end
      end
      tail_q    <= tail_q + free_num;
      rt_head_q <= rt_head_q + rt_num;
      // Squash rewinds to the retire head after this cycle's retires; squashed tags are still in place.
      head_q    <= exception_i ? (rt_head_q + rt_num) : (head_q + alloc_num);
    end
  end

  free_within_capacity: assert property (@(posedge clk_i) disable iff (rst_i) rt_num <= space);

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 C_DP_NUM, 3, number of dispatch allocation channels.
REQ-002 C_RT_NUM, 3, number of retire free channels.
REQ-003 C_ARCH_REG_NUM, 32, architectural register count.
REQ-004 C_PHY_REG_NUM, 64, physical register count; list depth C_FL_ENTRY_NUM = C_PHY_REG_NUM - C_ARCH_REG_NUM (32).
REQ-005 clk_i  in  1  single clock; all state updates on rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 dp_fl_i[C_DP_NUM]  in  1 each (new_pr_en)  allocation request per dispatch channel.
REQ-008 fl_dp_o[C_DP_NUM]  out  1 + TAG_IDX_WIDTH each (valid, tag)  offered free tag per channel.
REQ-009 rob_fl_i[C_RT_NUM]  in  1 + TAG_IDX_WIDTH each (valid, tag_old)  retired old tag to free.
REQ-010 exception_i  in  1  squash all speculative allocations.
REQ-011 avail_num_o  out  log2(C_FL_ENTRY_NUM)+1  current free-tag count.

Function
REQ-012 Storage: C_FL_ENTRY_NUM-entry circular tag buffer; head_ptr (allocate), tail_ptr (free), rt_head_ptr (retire head); each pointer carries one extra wrap bit.
REQ-013 avail_num_o = tail_ptr - head_ptr (wrap-bit arithmetic); full when count equals C_FL_ENTRY_NUM (equal indices, differing wrap bits).
REQ-014 fl_dp_o[n].tag = entry[head_ptr + n] modulo depth, combinational from current state.
REQ-015 fl_dp_o[n].valid = 1 iff avail_num_o > n; outputs combinational, no same-cycle bypass of freed tags.
REQ-016 new_pr_en asserted only on contiguous lowest channels; allocation count a = number of asserted new_pr_en with matching valid; requests on invalid channels are ignored.
REQ-017 Allocation: head_ptr advances by a at rising edge; zero-cycle latency (tag consumed in request cycle).
REQ-018 Free: retired tag_old on valid channels written to entry[tail_ptr + k] in channel order, k = count of valid channels below; tail_ptr advances by number freed f.
REQ-019 Each valid rob_fl_i channel also advances rt_head_ptr by one (retire order equals dispatch order).
REQ-020 Simultaneous allocate and free: next count = count - a + f; both applied same edge.
REQ-021 Free beyond full never occurs; simulation assertion flags it; tail_ptr saturates (no overwrite of unconsumed entries).
REQ-022 Exception: head_ptr <= rt_head_ptr + f (same-cycle retires applied first); allocations in that cycle ignored; frees written normally; resulting count = C_FL_ENTRY_NUM.
REQ-023 Tags between rt_head_ptr and head_ptr are never overwritten by frees (guaranteed by REQ-013 bound).
REQ-024 Wrap-around: all pointer arithmetic modulo 2*C_FL_ENTRY_NUM; entry index modulo C_FL_ENTRY_NUM.

Reset
REQ-025 rst_i high asynchronously sets entry[i] = C_ARCH_REG_NUM + i, head_ptr = rt_head_ptr = 0, tail_ptr = C_FL_ENTRY_NUM (full).
REQ-026 During reset: avail_num_o = 32, fl_dp_o tags 32,33,34 valid; inputs ignored.
REQ-027 Reset mid-operation discards all allocations and pending frees; state identical to REQ-025 within the same cycle rst_i rises.

Verification
REQ-028 Reset release -> avail_num_o 32, fl_dp_o tags 32/33/34, all valid=1.
REQ-029 Allocate 3/cycle for 10 cycles then 2 -> tags 32..63 issued in order, avail_num_o 0, all valid=0; further requests do not move head_ptr.
REQ-030 From empty, retire tag_old 5,6,7 on channels 0..2 -> next cycle avail_num_o 3, fl_dp_o tags 5,6,7 valid; same-cycle valid stays 0.
REQ-031 Reset, allocate 4 (tags 32..35), retire 1, then exception_i -> avail_num_o 32, fl_dp_o[0].tag 33.
REQ-032 avail_num_o 2, allocate 2 and free tags 40,41 same cycle -> avail_num_o 2, fl_dp_o tags 40,41.
REQ-033 Random dispatch/retire for 1000 cycles across pointer wrap -> no tag duplicated among free entries and in-flight tags; count never exceeds 32; rst_i asserted mid-run restores REQ-028 state immediately.
